// File: rtl/prog_timer.sv
// Programmable down-counting timer with run-time load value, prescaler,
// one-shot/periodic modes, stop/hold control and a live count readout.
module prog_timer #(
  parameter int WIDTH = 16,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PRE_W-1:0] prescale,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic             dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   load_r;
  logic [PRE_W-1:0]   pre_r;
  logic               mode_r;
  logic [PRE_W-1:0]   pre_cnt;

  // Control is level-sampled on every rising edge, no handshake: stop beats
  // start, start beats counting, and a start with load_val of zero is ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      load_r  <= '0;
      pre_r   <= '0;
      mode_r  <= 1'b0;
      pre_cnt <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        busy    <= 1'b0;
        count   <= '0;
        pre_cnt <= '0;
      end else if (start && (load_val != '0)) begin
        load_r  <= load_val;
        pre_r   <= prescale;
        mode_r  <= mode;
        count   <= load_val;
        pre_cnt <= prescale;
        state   <= RUN;
        busy    <= 1'b1;
      end else if ((state == RUN) && !hold) begin
        if (pre_cnt != '0) begin
          pre_cnt <= pre_cnt - PRE_W'(1);
        end else if (count == WIDTH'(1)) begin
          // Expiry tick: periodic reloads with no gap cycle, one-shot parks at 0.
          done    <= 1'b1;
          pre_cnt <= pre_r;
          if (mode_r) begin
            count <= load_r;
          end else begin
            count <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else if (count != '0) begin
          count   <= count - WIDTH'(1);
          pre_cnt <= pre_r;
        end
      end
    end
  end

  assign dbg_state = (state == RUN);

endmodule

// File: tb/tb_prog_timer.sv
// Directed bench for prog_timer: edge k is the k-th rising edge after the
// edge that sampled start (edge 0); outputs are sampled 1ns after each edge.
module tb_prog_timer;

  localparam int WIDTH = 16;
  localparam int PRE_W = 8;

  logic             clk;
  logic             rstn;
  logic             start;
  logic             stop;
  logic             hold;
  logic             mode;
  logic [WIDTH-1:0] load_val;
  logic [PRE_W-1:0] prescale;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;
  logic             dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  prog_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .stop      (stop),
    .hold      (hold),
    .mode      (mode),
    .load_val  (load_val),
    .prescale  (prescale),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m, input int lv, input int ps);
    mode     = m;
    load_val = WIDTH'(lv);
    prescale = PRE_W'(ps);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic check_outs(input string tag, input int k, input int e_cnt,
                            input int e_busy, input int e_done);
    check($sformatf("%s count k=%0d", tag, k), 32'(count), 32'(e_cnt));
    check($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(e_busy));
    check($sformatf("%s done k=%0d", tag, k), 32'(done), 32'(e_done));
  endtask

  initial begin
    int e;
    rstn = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0;
    load_val = '0; prescale = '0;
    #12;
    check_outs("reset", 0, 0, 0, 0);
    check("reset state", 32'(dbg_state), 32'd0);
    rstn = 1'b1;
    tick();

    // one-shot 16, prescale 0
    do_start(1'b0, 16, 0);
    check_outs("os", 0, 16, 1, 0);
    check("os state", 32'(dbg_state), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_outs("os", k, (k < 16) ? 16 - k : 0, (k < 16) ? 1 : 0, (k == 16) ? 1 : 0);
    end

    // periodic 4, prescale 2: 12-edge period
    do_start(1'b1, 4, 2);
    check_outs("per", 0, 4, 1, 0);
    for (int k = 1; k <= 38; k++) begin
      tick();
      check_outs("per", k, 4 - ((k % 12) / 3), 1, ((k % 12) == 0) ? 1 : 0);
    end
    do_stop();
    check_outs("per stop", 0, 0, 0, 0);

    // hold sampled high on edges 5..9
    do_start(1'b0, 16, 0);
    for (int k = 1; k <= 23; k++) begin
      hold = (k >= 5 && k <= 9);
      tick();
      if (k < 5) e = 16 - k;
      else if (k <= 9) e = 12;
      else e = (k < 21) ? 21 - k : 0;
      check_outs("hold", k, e, (k < 21) ? 1 : 0, (k == 21) ? 1 : 0);
    end
    hold = 1'b0;

    // stop at edge 10
    do_start(1'b0, 16, 0);
    for (int k = 1; k <= 9; k++) tick();
    check("stop10 pre count", 32'(count), 32'd7);
    do_stop();
    check_outs("stop10", 10, 0, 0, 0);
    for (int k = 11; k <= 20; k++) begin
      tick();
      check_outs("stop10 after", k, 0, 0, 0);
    end

    // stop coincident with expiry edge 16
    do_start(1'b0, 16, 0);
    for (int k = 1; k <= 15; k++) tick();
    check("stopexp pre count", 32'(count), 32'd1);
    do_stop();
    check_outs("stopexp", 16, 0, 0, 0);
    tick();
    check_outs("stopexp after", 17, 0, 0, 0);

    // restart at edge 8
    do_start(1'b0, 16, 0);
    for (int k = 1; k <= 26; k++) begin
      start = (k == 8);
      tick();
      if (k < 8) e = 16 - k;
      else e = (k < 24) ? 24 - k : 0;
      check_outs("restart", k, e, (k < 24) ? 1 : 0, (k == 24) ? 1 : 0);
    end
    start = 1'b0;

    // start with load_val 0 in IDLE is ignored
    do_start(1'b0, 0, 3);
    check_outs("zero", 0, 0, 0, 0);
    check("zero state", 32'(dbg_state), 32'd0);
    tick();
    check_outs("zero", 1, 0, 0, 0);

    // asynchronous reset at edge 7 of a periodic 3/0 run
    do_start(1'b1, 3, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_outs("rst run", k, ((k % 3) == 0) ? 3 : 3 - (k % 3), 1, ((k % 3) == 0) ? 1 : 0);
    end
    #2;
    rstn = 1'b0;
    #1;
    check_outs("rst async", 7, 0, 0, 0);
    check("rst async state", 32'(dbg_state), 32'd0);
    tick();
    #2;
    rstn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_outs("rst after", k, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_timer.md
# prog_timer

Programmable down-counting timer: generalises the fixed-delay `DELAY` timer with a run-time load value and prescaler, one-shot and periodic modes, start/stop/hold control, and a live count readout. It is a reusable timing source for control FSMs, timeouts and periodic-tick generation, and needs no re-synthesis when the delay changes.

## Interface
- `WIDTH`, 16: width of the load value and main counter.
- `PRE_W`, 8: width of the prescaler value and prescaler counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  sampled each edge; loads and (re)starts the timer.
- `stop`  in  1  sampled each edge; aborts the timer and returns it to IDLE.
- `hold`  in  1  level; while high in RUN, both counters freeze.
- `mode`  in  1  captured on start: 0 = one-shot, 1 = periodic.
- `load_val`  in  WIDTH  ticks per period, captured on start.
- `prescale`  in  PRE_W  clocks per tick minus 1, captured on start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse per expiry.
- `count`  out  WIDTH  current main-counter value.

## Operation
- Two states: IDLE and RUN. Internal registers: `load_r`, `pre_r`, `mode_r`, `pre_cnt`, `count`.
- Priority at each edge, highest first: `stop`, then `start`, then counting.
- `stop`=1, any state: go to IDLE; `count`=0, `pre_cnt`=0; no `done` that edge, even if expiry coincides. `stop` in IDLE has no other effect.
- `start`=1, `stop`=0, `load_val`≠0, any state:
  - Capture `load_r`, `pre_r` and `mode_r`.
  - Set `count`=`load_val` and `pre_cnt`=`prescale`; go to RUN.
  - `start` in RUN restarts the timer; the period in progress is discarded with no `done`.
- `start` with `load_val`=0 is ignored: state and registers are unchanged.
- RUN with `hold`=0, no `start` and no `stop`:
  - If `pre_cnt`≠0, decrement `pre_cnt`.
  - Otherwise reload `pre_cnt`=`pre_r` and decrement `count`. This is a tick.
- Expiry is the tick on which `count` goes from 1 to 0. On that edge `done`=1 for the following cycle.
  - One-shot: go to IDLE, leave `count`=0.
  - Periodic: reload `count`=`load_r` and `pre_cnt`=`pre_r`, and stay in RUN.
- RUN with `hold`=1: `pre_cnt` and `count` are frozen. `start` and `stop` still act.
- Arithmetic is unsigned. `count` never underflows: no tick occurs at 0 in RUN.

## Timing
- Reset values, asserted asynchronously: state=IDLE, `busy`=0, `done`=0, `count`=0; all internal registers 0.
- All outputs are registered. `busy`=1 from the cycle after the start edge.
- Expiry latency is exactly `load_val`×(`prescale`+1) rising edges after the start-sampling edge, plus the number of `hold`-high cycles in between.
  - `done` is high for the cycle following that edge.
- One-shot: `busy` falls in the same cycle that `done` rises.
- Periodic: `done` pulses every `load_val`×(`prescale`+1) cycles, with no gap cycle at reload.
- Reset mid-run: outputs return to their reset values immediately; after release the timer stays in IDLE until the next `start`.

## Test plan
- One-shot, `load_val`=16, `prescale`=0, start at edge 0 → `done` high only in the cycle after edge 16, exactly once; `busy` low from that cycle; `count` holds 0.
- Periodic, `load_val`=4, `prescale`=2 → `done` pulses after edges 12, 24, 36; `count` sequence 4,4,4,3,3,3,… with reload to 4 at each expiry; `busy` stays high.
- `hold` high for 5 cycles mid-run (one-shot, 16, 0) → `done` after edge 21; `count` frozen during hold.
- `stop` at edge 10 (16, 0), then `stop` coincident with the expiry edge on a second run → no `done` either time; `busy`=0 and `count`=0 after each stop.
- `start` again at edge 8 of a running (16, 0) one-shot → `done` after edge 24 only. Separately, `start` with `load_val`=0 in IDLE → `busy` stays 0.
- `rstn` pulsed low at edge 7 of a periodic run → `busy`, `done` and `count` go to 0 asynchronously; no `done` occurs until a new `start`.
